// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit.
// Sequences PC, IR, ALU, unified memory and the register bank from the opcode held in the IR.
// Control outputs are Moore decodes of the current state. pcen also depends on the ALU zero
// flag, and the FETCH write strobes depend on the memory handshake.
// A retired-instruction counter advances when each instruction completes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  | read registers, precompute branch target into ALUOut
// MEMADR  | effective address = A + sign-ext imm
// MEMRD   | load data from ALUOut address, wait for memory
// MEMWB   | write loaded data to rt
// MEMWR   | store B to ALUOut address, wait for memory
// RTYPEEX | ALU op on A,B selected by funct
// RTYPEWB | write ALUOut to rd
// BEQEX   | compare A,B; take branch to ALUOut when zero
// ADDIEX  | A + sign-ext imm
// ADDIWB  | write ALUOut to rt
// JEX     | load PC with jump target
module mips_mc_control #(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter int COUNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               memwrite,
   output logic               irwrite,
   output logic               iord,
   output logic               pcen,
   output logic [1:0]         pcsrc,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         aluop,
   output logic               regwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               illegal_op,
   output logic [3:0]         state,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t             state_q;
   state_t             state_d;
   logic [COUNT_W-1:0] count_q;
   logic               ready;

   // Ungated decode values; reset forces them off at the outputs.
   logic       c_memwrite;
   logic       c_irwrite;
   logic       c_iord;
   logic       c_pcwrite;
   logic       c_branch;
   logic [1:0] c_pcsrc;
   logic       c_alusrca;
   logic [1:0] c_alusrcb;
   logic [1:0] c_aluop;
   logic       c_regwrite;
   logic       c_regdst;
   logic       c_memtoreg;
   logic       c_illegal;
   logic       retire;

   // With waits disabled the memory is treated as always completing in one cycle.
   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   // State register and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire)
            count_q <= count_q + COUNT_W'(1);
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      state_d    = S_FETCH;
      c_memwrite = 1'b0;
      c_irwrite  = 1'b0;
      c_iord     = 1'b0;
      c_pcwrite  = 1'b0;
      c_branch   = 1'b0;
      c_pcsrc    = 2'b00;
      c_alusrca  = 1'b0;
      c_alusrcb  = 2'b00;
      c_aluop    = 2'b00;
      c_regwrite = 1'b0;
      c_regdst   = 1'b0;
      c_memtoreg = 1'b0;
      c_illegal  = 1'b0;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            c_alusrcb = 2'b01;
            c_irwrite = ready;
            c_pcwrite = ready;
            state_d   = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            c_alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default: begin
                  state_d   = S_FETCH;
                  c_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            c_alusrca = 1'b1;
            c_alusrcb = 2'b10;
            // IR is not reloaded here, so op still holds the decoded opcode.
            state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            c_iord  = 1'b1;
            state_d = ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            c_regwrite = 1'b1;
            c_memtoreg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            c_iord     = 1'b1;
            c_memwrite = 1'b1;
            retire     = ready;
            state_d    = ready ? S_FETCH : S_MEMWR;
         end
         S_RTYPEEX: begin
            c_alusrca = 1'b1;
            c_aluop   = 2'b10;
            state_d   = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            c_regwrite = 1'b1;
            c_regdst   = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQEX: begin
            c_alusrca = 1'b1;
            c_aluop   = 2'b01;
            c_pcsrc   = 2'b01;
            c_branch  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            c_alusrca = 1'b1;
            c_alusrcb = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            c_regwrite = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JEX: begin
            c_pcsrc   = 2'b10;
            c_pcwrite = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Reset suppresses every strobe immediately, including mid-instruction.
   always_comb begin
      memwrite   = c_memwrite & ~rst;
      irwrite    = c_irwrite  & ~rst;
      iord       = c_iord     & ~rst;
      pcen       = (c_pcwrite | (c_branch & zero)) & ~rst;
      pcsrc      = rst ? 2'b00 : c_pcsrc;
      alusrca    = c_alusrca  & ~rst;
      alusrcb    = rst ? 2'b00 : c_alusrcb;
      aluop      = rst ? 2'b00 : c_aluop;
      regwrite   = c_regwrite & ~rst;
      regdst     = c_regdst   & ~rst;
      memtoreg   = c_memtoreg & ~rst;
      illegal_op = c_illegal  & ~rst;
   end

   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for the multicycle control unit. A second instance with memory waits
// disabled runs on the same inputs for the handshake-latency comparison.
module tb_mips_mc_control;

   logic        clk;
   logic        rst;
   logic [5:0]  op;
   logic        zero;
   logic        mem_ready;

   logic        memwrite, irwrite, iord, pcen, alusrca, regwrite, regdst, memtoreg, illegal_op;
   logic [1:0]  pcsrc, alusrcb, aluop;
   logic [3:0]  state;
   logic [31:0] instr_count;

   logic        memwrite2, irwrite2, iord2, pcen2, alusrca2, regwrite2, regdst2, memtoreg2, illegal_op2;
   logic [1:0]  pcsrc2, alusrcb2, aluop2;
   logic [3:0]  state2;
   logic [31:0] instr_count2;

   logic [14:0] ctl, ctl2;
   int          n_cmp = 0;
   int          n_err = 0;

   // ctl = {memwrite, irwrite, iord, pcen, pcsrc, alusrca, alusrcb, aluop, regwrite, regdst, memtoreg, illegal_op}
   assign ctl  = {memwrite, irwrite, iord, pcen, pcsrc, alusrca, alusrcb, aluop,
                  regwrite, regdst, memtoreg, illegal_op};
   assign ctl2 = {memwrite2, irwrite2, iord2, pcen2, pcsrc2, alusrca2, alusrcb2, aluop2,
                  regwrite2, regdst2, memtoreg2, illegal_op2};

   localparam logic [14:0] C_NONE    = 15'b0_0_0_0_00_0_00_00_0_0_0_0;
   localparam logic [14:0] C_F_RDY   = 15'b0_1_0_1_00_0_01_00_0_0_0_0;
   localparam logic [14:0] C_F_STALL = 15'b0_0_0_0_00_0_01_00_0_0_0_0;
   localparam logic [14:0] C_DEC     = 15'b0_0_0_0_00_0_11_00_0_0_0_0;
   localparam logic [14:0] C_DEC_ILL = 15'b0_0_0_0_00_0_11_00_0_0_0_1;
   localparam logic [14:0] C_MEMADR  = 15'b0_0_0_0_00_1_10_00_0_0_0_0;
   localparam logic [14:0] C_MEMRD   = 15'b0_0_1_0_00_0_00_00_0_0_0_0;
   localparam logic [14:0] C_MEMWB   = 15'b0_0_0_0_00_0_00_00_1_0_1_0;
   localparam logic [14:0] C_MEMWR   = 15'b1_0_1_0_00_0_00_00_0_0_0_0;
   localparam logic [14:0] C_RTEX    = 15'b0_0_0_0_00_1_00_10_0_0_0_0;
   localparam logic [14:0] C_RTWB    = 15'b0_0_0_0_00_0_00_00_1_1_0_0;
   localparam logic [14:0] C_BEQ_T   = 15'b0_0_0_1_01_1_00_01_0_0_0_0;
   localparam logic [14:0] C_BEQ_N   = 15'b0_0_0_0_01_1_00_01_0_0_0_0;
   localparam logic [14:0] C_ADDIEX  = 15'b0_0_0_0_00_1_10_00_0_0_0_0;
   localparam logic [14:0] C_ADDIWB  = 15'b0_0_0_0_00_0_00_00_1_0_0_0;
   localparam logic [14:0] C_JEX     = 15'b0_0_0_1_10_0_00_00_0_0_0_0;

   mips_mc_control #(.MEM_WAIT_EN(1'b1), .COUNT_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .memwrite(memwrite), .irwrite(irwrite), .iord(iord), .pcen(pcen), .pcsrc(pcsrc),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regwrite(regwrite),
      .regdst(regdst), .memtoreg(memtoreg), .illegal_op(illegal_op), .state(state),
      .instr_count(instr_count)
   );

   mips_mc_control #(.MEM_WAIT_EN(1'b0), .COUNT_W(32)) dut_nw (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .memwrite(memwrite2), .irwrite(irwrite2), .iord(iord2), .pcen(pcen2), .pcsrc(pcsrc2),
      .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2), .regwrite(regwrite2),
      .regdst(regdst2), .memtoreg(memtoreg2), .illegal_op(illegal_op2), .state(state2),
      .instr_count(instr_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 with inputs already set: check state/controls, then advance one cycle.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] c);
      #1;
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".ctl"}, 32'(ctl), 32'(c));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      op        = 6'b100011;
      zero      = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.count", instr_count, 32'd0);
      chk("rst.ctl", 32'(ctl), 32'(C_NONE));
      chk("rst.ctl_nw", 32'(ctl2), 32'(C_NONE));
      rst = 1'b0;

      // lw
      cyc("lw.f", 4'd0, C_F_RDY);
      cyc("lw.dec", 4'd1, C_DEC);
      cyc("lw.adr", 4'd2, C_MEMADR);
      cyc("lw.rd", 4'd3, C_MEMRD);
      cyc("lw.wb", 4'd4, C_MEMWB);
      chk("lw.count", instr_count, 32'd1);

      // R-type
      op = 6'b000000;
      cyc("rt.f", 4'd0, C_F_RDY);
      cyc("rt.dec", 4'd1, C_DEC);
      cyc("rt.ex", 4'd6, C_RTEX);
      cyc("rt.wb", 4'd7, C_RTWB);
      chk("rt.count", instr_count, 32'd2);

      // sw
      op = 6'b101011;
      cyc("sw.f", 4'd0, C_F_RDY);
      cyc("sw.dec", 4'd1, C_DEC);
      cyc("sw.adr", 4'd2, C_MEMADR);
      cyc("sw.wr", 4'd5, C_MEMWR);
      chk("sw.count", instr_count, 32'd3);

      // beq taken then not taken
      op = 6'b000100;
      zero = 1'b1;
      cyc("beq1.f", 4'd0, C_F_RDY);
      cyc("beq1.dec", 4'd1, C_DEC);
      cyc("beq1.ex", 4'd8, C_BEQ_T);
      chk("beq1.count", instr_count, 32'd4);
      zero = 1'b0;
      cyc("beq0.f", 4'd0, C_F_RDY);
      cyc("beq0.dec", 4'd1, C_DEC);
      cyc("beq0.ex", 4'd8, C_BEQ_N);
      chk("beq0.count", instr_count, 32'd5);

      // j
      op = 6'b000010;
      cyc("j.f", 4'd0, C_F_RDY);
      cyc("j.dec", 4'd1, C_DEC);
      cyc("j.ex", 4'd11, C_JEX);
      chk("j.count", instr_count, 32'd6);

      // illegal opcode: one-cycle pulse, back to FETCH, not counted
      op = 6'b111111;
      cyc("ill.f", 4'd0, C_F_RDY);
      cyc("ill.dec", 4'd1, C_DEC_ILL);
      cyc("ill.after", 4'd0, C_F_RDY);
      chk("ill.count", instr_count, 32'd6);

      // addi to completion
      op = 6'b001000;
      cyc("addi.dec", 4'd1, C_DEC);
      cyc("addi.ex", 4'd9, C_ADDIEX);
      cyc("addi.wb", 4'd10, C_ADDIWB);
      chk("addi.count", instr_count, 32'd7);

      // addi aborted by reset in ADDIEX
      cyc("addr.f", 4'd0, C_F_RDY);
      cyc("addr.dec", 4'd1, C_DEC);
      rst = 1'b1;
      #1;
      chk("addr.state9", 32'(state), 32'd9);
      chk("addr.ctl_rst", 32'(ctl), 32'(C_NONE));
      @(posedge clk);
      #1;
      chk("addr.state0", 32'(state), 32'd0);
      chk("addr.count0", instr_count, 32'd0);
      chk("addr.no_regwrite", 32'(regwrite), 32'd0);
      rst = 1'b0;

      // memory stalls: 3 cycles in FETCH, 3 in MEMRD -> 11 cycles; no-wait copy takes 5
      op = 6'b100011;
      mem_ready = 1'b0;
      cyc("st.f1", 4'd0, C_F_STALL);
      cyc("st.f2", 4'd0, C_F_STALL);
      cyc("st.f3", 4'd0, C_F_STALL);
      mem_ready = 1'b1;
      cyc("st.f4", 4'd0, C_F_RDY);
      chk("nw.state4", 32'(state2), 32'd4);
      cyc("st.dec", 4'd1, C_DEC);
      chk("nw.state0", 32'(state2), 32'd0);
      chk("nw.count", instr_count2, 32'd1);
      cyc("st.adr", 4'd2, C_MEMADR);
      mem_ready = 1'b0;
      cyc("st.rd1", 4'd3, C_MEMRD);
      cyc("st.rd2", 4'd3, C_MEMRD);
      cyc("st.rd3", 4'd3, C_MEMRD);
      mem_ready = 1'b1;
      cyc("st.rd4", 4'd3, C_MEMRD);
      chk("st.count_pre", instr_count, 32'd0);
      cyc("st.wb", 4'd4, C_MEMWB);
      chk("st.state_end", 32'(state), 32'd0);
      chk("st.count", instr_count, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
